// File: rtl/mem_wb.sv
// Memory-access / write-back stage: takes the execute result pulse, runs a
// load or store over the req/ack data-memory handshake, then retires.
module mem_wb #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ex_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [4:0]          i_rd,
    input  logic [1:0]          i_type,
    output logic                o_dmem_req,
    output logic                o_dmem_we,
    output logic [ADDR_W-4:0]   o_dmem_addr,
    output logic [DATA_W-1:0]   o_dmem_wdata,
    input  logic                i_dmem_ack,
    input  logic [DATA_W-1:0]   i_dmem_rdata,
    output logic                o_wb_en,
    output logic [4:0]          o_wb_rd,
    output logic [DATA_W-1:0]   o_wb_data,
    output logic                o_retire,
    output logic                o_pc_inc,
    output logic                o_busy,
    output logic                o_misalign,
    output logic                o_bus_err,
    output logic                o_overrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] TYPE_LD  = 2'd0;
    localparam logic [1:0] TYPE_SD  = 2'd1;
    localparam logic [1:0] TYPE_BR  = 2'd2;
    localparam logic [1:0] TYPE_ALU = 2'd3;

    // Last MEM cycle count value before the wait is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_reg;
    logic [4:0] rd_reg;
    logic [7:0] tmo_cnt_reg;

    // Retire/write-back outputs are set on the edge that enters DONE, so the
    // DONE cycle itself only clears them and returns to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            rd_reg       <= '0;
            tmo_cnt_reg  <= '0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_wb_en      <= 1'b0;
            o_wb_rd      <= '0;
            o_wb_data    <= '0;
            o_retire     <= 1'b0;
            o_pc_inc     <= 1'b0;
            o_busy       <= 1'b0;
            o_misalign   <= 1'b0;
            o_bus_err    <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_wb_en  <= 1'b0;
            o_retire <= 1'b0;
            o_pc_inc <= 1'b0;

            if (i_ex_valid && state_reg != IDLE) begin
                o_overrun <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (i_ex_valid) begin
                        rd_reg <= i_rd;
                        o_busy <= 1'b1;
                        case (i_type)
                            TYPE_BR: begin
                                state_reg <= DONE;
                                o_retire  <= 1'b1;
                            end
                            TYPE_ALU: begin
                                state_reg <= DONE;
                                o_retire  <= 1'b1;
                                o_pc_inc  <= 1'b1;
                                if (i_rd != 5'd0) begin
                                    o_wb_en   <= 1'b1;
                                    o_wb_rd   <= i_rd;
                                    o_wb_data <= DATA_W'(i_addr);
                                end
                            end
                            default: begin
                                if (i_addr[2:0] != 3'd0) begin
                                    o_misalign <= 1'b1;
                                    state_reg  <= DONE;
                                    o_retire   <= 1'b1;
                                    o_pc_inc   <= 1'b1;
                                end else begin
                                    state_reg    <= MEM;
                                    o_dmem_req   <= 1'b1;
                                    o_dmem_we    <= (i_type == TYPE_SD);
                                    o_dmem_addr  <= i_addr[ADDR_W-1:3];
                                    o_dmem_wdata <= i_data;
                                end
                            end
                        endcase
                    end
                end

                MEM: begin
                    if (i_dmem_ack) begin
                        o_dmem_req  <= 1'b0;
                        tmo_cnt_reg <= '0;
                        state_reg   <= DONE;
                        o_retire    <= 1'b1;
                        o_pc_inc    <= 1'b1;
                        if (!o_dmem_we && rd_reg != 5'd0) begin
                            o_wb_en   <= 1'b1;
                            o_wb_rd   <= rd_reg;
                            o_wb_data <= i_dmem_rdata;
                        end
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        o_dmem_req  <= 1'b0;
                        o_bus_err   <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= DONE;
                        o_retire    <= 1'b1;
                        o_pc_inc    <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    o_busy    <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: ALU, load, store, branch, x0, misalign,
// timeout, overrun and mid-operation reset, checked cycle by cycle.
module tb_mem_wb;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [63:0] addr;
    logic [63:0] data;
    logic [4:0]  rd;
    logic [1:0]  typ;
    logic        dmem_req;
    logic        dmem_we;
    logic [60:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        retire;
    logic        pc_inc;
    logic        busy;
    logic        misalign;
    logic        bus_err;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    mem_wb #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ex_valid   (ex_valid),
        .i_addr       (addr),
        .i_data       (data),
        .i_rd         (rd),
        .i_type       (typ),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_wdata (dmem_wdata),
        .i_dmem_ack   (dmem_ack),
        .i_dmem_rdata (dmem_rdata),
        .o_wb_en      (wb_en),
        .o_wb_rd      (wb_rd),
        .o_wb_data    (wb_data),
        .o_retire     (retire),
        .o_pc_inc     (pc_inc),
        .o_busy       (busy),
        .o_misalign   (misalign),
        .o_bus_err    (bus_err),
        .o_overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] t, input logic [63:0] a, input logic [63:0] d, input logic [4:0] r);
        ex_valid = 1'b1;
        typ      = t;
        addr     = a;
        data     = d;
        rd       = r;
        tick();
        ex_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ex_valid   = 1'b0;
        addr       = '0;
        data       = '0;
        rd         = '0;
        typ        = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        tick();
        tick();
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", {61'd0, misalign, bus_err, overrun}, 64'd0);
        rst_n = 1'b1;
        tick();

        // ALU: retire and write-back in T+1, quiet in T+2
        issue(2'd3, 64'h1234, 64'h0, 5'd5);
        chk("alu_wb_en", 64'(wb_en), 64'd1);
        chk("alu_wb_rd", 64'(wb_rd), 64'd5);
        chk("alu_wb_data", wb_data, 64'h1234);
        chk("alu_retire", 64'(retire), 64'd1);
        chk("alu_pc_inc", 64'(pc_inc), 64'd1);
        chk("alu_busy", 64'(busy), 64'd1);
        chk("alu_req", 64'(dmem_req), 64'd0);
        tick();
        chk("alu2_pulses", {61'd0, wb_en, retire, pc_inc}, 64'd0);
        chk("alu2_busy", 64'(busy), 64'd0);
        chk("alu2_hold", wb_data, 64'h1234);

        // Load acked in the third MEM cycle
        issue(2'd0, 64'h40, 64'h0, 5'd7);
        chk("ld_req1", 64'(dmem_req), 64'd1);
        chk("ld_we", 64'(dmem_we), 64'd0);
        chk("ld_addr", 64'(dmem_addr), 64'h8);
        chk("ld_retire1", 64'(retire), 64'd0);
        tick();
        chk("ld_req2", 64'(dmem_req), 64'd1);
        tick();
        chk("ld_req3", 64'(dmem_req), 64'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEADBEEF;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        chk("ld_req4", 64'(dmem_req), 64'd0);
        chk("ld_wb_en", 64'(wb_en), 64'd1);
        chk("ld_wb_rd", 64'(wb_rd), 64'd7);
        chk("ld_wb_data", wb_data, 64'hDEADBEEF);
        chk("ld_retire", 64'(retire), 64'd1);
        chk("ld_pc_inc", 64'(pc_inc), 64'd1);
        tick();
        chk("ld_after", {62'd0, wb_en, busy}, 64'd0);

        // Store acked on the first MEM cycle
        issue(2'd1, 64'h18, 64'h55, 5'd9);
        chk("sd_req", 64'(dmem_req), 64'd1);
        chk("sd_we", 64'(dmem_we), 64'd1);
        chk("sd_addr", 64'(dmem_addr), 64'h3);
        chk("sd_wdata", dmem_wdata, 64'h55);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("sd_retire", 64'(retire), 64'd1);
        chk("sd_pc_inc", 64'(pc_inc), 64'd1);
        chk("sd_wb_en", 64'(wb_en), 64'd0);
        chk("sd_req_drop", 64'(dmem_req), 64'd0);
        chk("sd_hold", wb_data, 64'hDEADBEEF);
        tick();

        // Branch: retire without PC increment or write-back
        issue(2'd2, 64'h999, 64'h0, 5'd3);
        chk("br_retire", 64'(retire), 64'd1);
        chk("br_pc_inc", 64'(pc_inc), 64'd0);
        chk("br_wb_en", 64'(wb_en), 64'd0);
        tick();

        // ALU to x0: retire, no write-back, wb_rd holds
        issue(2'd3, 64'h77, 64'h0, 5'd0);
        chk("x0_retire", 64'(retire), 64'd1);
        chk("x0_wb_en", 64'(wb_en), 64'd0);
        chk("x0_wb_rd", 64'(wb_rd), 64'd7);
        tick();

        // Misaligned load
        issue(2'd0, 64'h43, 64'h0, 5'd4);
        chk("mis_req", 64'(dmem_req), 64'd0);
        chk("mis_flag", 64'(misalign), 64'd1);
        chk("mis_retire", 64'(retire), 64'd1);
        chk("mis_wb_en", 64'(wb_en), 64'd0);
        tick();
        chk("mis_sticky", 64'(misalign), 64'd1);

        // Load never acked: req for exactly TIMEOUT=4 cycles
        issue(2'd0, 64'h80, 64'h0, 5'd6);
        chk("tmo_req1", 64'(dmem_req), 64'd1);
        chk("tmo_err1", 64'(bus_err), 64'd0);
        tick();
        tick();
        tick();
        chk("tmo_req4", 64'(dmem_req), 64'd1);
        chk("tmo_retire4", 64'(retire), 64'd0);
        tick();
        chk("tmo_req5", 64'(dmem_req), 64'd0);
        chk("tmo_err", 64'(bus_err), 64'd1);
        chk("tmo_retire", 64'(retire), 64'd1);
        chk("tmo_wb_en", 64'(wb_en), 64'd0);
        tick();

        // Second ex_valid during MEM is an overrun; load still completes
        issue(2'd0, 64'h100, 64'h0, 5'd10);
        chk("ovr_req1", 64'(dmem_req), 64'd1);
        chk("ovr_flag0", 64'(overrun), 64'd0);
        issue(2'd3, 64'h5555, 64'h0, 5'd11);
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_req2", 64'(dmem_req), 64'd1);
        chk("ovr_addr", 64'(dmem_addr), 64'h20);
        chk("ovr_retire2", 64'(retire), 64'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hCAFE;
        tick();
        dmem_ack   = 1'b0;
        chk("ovr_wb_en", 64'(wb_en), 64'd1);
        chk("ovr_wb_rd", 64'(wb_rd), 64'd10);
        chk("ovr_wb_data", wb_data, 64'hCAFE);
        tick();
        chk("ovr_after", {61'd0, busy, retire, wb_en}, 64'd0);

        // Reset in the middle of MEM
        issue(2'd0, 64'h200, 64'h0, 5'd12);
        chk("rmid_req1", 64'(dmem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_req_async", 64'(dmem_req), 64'd0);
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_flags", {61'd0, misalign, bus_err, overrun}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rmid_retire1", {61'd0, retire, wb_en, busy}, 64'd0);
        tick();
        chk("rmid_retire2", {61'd0, retire, wb_en, dmem_req}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
